// File: rtl/pacman_sprite_fetch.sv
// pacman_sprite_fetch: 3-stage sprite ROM fetch with per-direction transform and clip-to-screen hit test.
// Define PACMAN_ANIM_EN to build the mouth animation FSM; otherwise the sprite stays in the CLOSED frame.
module pacman_sprite_fetch #(
  parameter int         ANIM_DIV   = 4,
  parameter logic [4:0] TRANSP_IDX = 5'd1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic       pixel_valid,
  input  logic       frame_tick,
  input  logic [9:0] pac_x,
  input  logic [9:0] pac_y,
  input  logic [1:0] pac_dir,
  input  logic       pac_moving,
  output logic [9:0] rom_addr,
  input  logic [4:0] rom_data,
  output logic [4:0] sprite_index,
  output logic       sprite_hit
);
  logic [9:0] px_s, py_s;
  logic [1:0] dir_s, frame;
  logic [10:0] dx, dy;
  logic [3:0] row, col;
  logic in_box, v1, v2, opaque;
  // Zero-extended subtraction: a negative offset sets the upper bits, so screen edges clip without wrap.
  always_comb begin
    dx = {1'b0, draw_x} - {1'b0, px_s};
    dy = {1'b0, draw_y} - {1'b0, py_s};
    in_box = pixel_valid && dx[10:4] == 7'd0 && dy[10:4] == 7'd0;
    row = dir_s[1] ? (dir_s[0] ? 4'd15 - dx[3:0] : dx[3:0]) : dy[3:0];
    col = dir_s[1] ? dy[3:0] : (dir_s[0] ? 4'd15 - dx[3:0] : dx[3:0]);
    opaque = v2 && rom_data != TRANSP_IDX;
  end
`ifdef PACMAN_ANIM_EN
  typedef enum logic [1:0] {CLOSED, HALF_OPEN, OPEN, HALF_CLOSE} anim_t;
  anim_t state;
  logic [3:0] div;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= CLOSED;
      div <= 4'd0;
    end else if (frame_tick && pac_moving) begin
      div <= div == 4'(ANIM_DIV - 1) ? 4'd0 : div + 4'd1;
      state <= div == 4'(ANIM_DIV - 1) ? anim_t'(state + 2'd1) : state;
    end
  assign frame = state == OPEN ? 2'd2 : state == CLOSED ? 2'd0 : 2'd1;
`else
  logic unused_moving;
  assign unused_moving = pac_moving;
  assign frame = 2'd0;
`endif
  always_ff @(posedge clk)
    if (!reset_n) begin
      px_s <= 10'd0;
      py_s <= 10'd0;
      dir_s <= 2'd0;
      rom_addr <= 10'd0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      sprite_hit <= 1'b0;
      sprite_index <= 5'd0;
    end else begin
      if (frame_tick) begin
        px_s <= pac_x;
        py_s <= pac_y;
        dir_s <= pac_dir;
      end
      rom_addr <= {frame, row, col};
      v1 <= in_box;
      v2 <= v1;
      sprite_hit <= opaque;
      sprite_index <= opaque ? rom_data : 5'd0;
    end
endmodule

// File: doc/pacman_sprite_fetch.md
PACMAN_SPRITE_FETCH -- requirements
Module: pacman_sprite_fetch

Interface
REQ-001 SHALL have parameter ANIM_DIV, default 4: frame_tick pulses per animation step, legal range 1..15.
REQ-002 SHALL have parameter TRANSP_IDX, default 5'd1: palette index treated as transparent.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port draw_x, input, 10 bits: current pixel column, 0..639.
REQ-006 SHALL have port draw_y, input, 10 bits: current pixel row, 0..479.
REQ-007 SHALL have port pixel_valid, input, 1 bit: draw_x/draw_y are in the active area.
REQ-008 SHALL have port frame_tick, input, 1 bit: one-cycle pulse at the start of vertical blank.
REQ-009 SHALL have port pac_x and pac_y, inputs, 10 bits each: sprite top-left corner.
REQ-010 SHALL have port pac_dir, input, 2 bits: direction, where 0 = right, 1 = left, 2 = up, 3 = down.
REQ-011 SHALL have port pac_moving, input, 1 bit: animation advances only while this is 1.
REQ-012 SHALL have port rom_addr, output, 10 bits: sprite ROM address, formatted as {frame[1:0], row[3:0], col[3:0]}.
REQ-013 SHALL have port rom_data, input, 5 bits: ROM palette index, returned one cycle after rom_addr.
REQ-014 SHALL have port sprite_index, output, 5 bits: index to the downstream palette lookup.
REQ-015 SHALL have port sprite_hit, output, 1 bit: the current pixel is an opaque sprite pixel.

Function
REQ-016 SHALL latch pac_x, pac_y and pac_dir into shadow registers only on the frame_tick cycle, so there is no mid-frame tearing.
REQ-017 SHALL compute dx = draw_x - pac_x_shadow and dy = draw_y - pac_y_shadow as 11-bit signed values; the pixel is inside the box when both are in 0..15 and pixel_valid = 1.
REQ-018 SHALL clip the sprite at the screen edges, with no wrap-around: a sprite at pac_x = 630 covers columns 630..639 only.
REQ-019 SHALL transform (r, c) = (dy[3:0], dx[3:0]) by the shadow direction:
- right: (r, c)
- left: (r, 15-c)
- up: (c, r)
- down: (15-c, r)
REQ-020 Stage 1 SHALL register rom_addr = {anim_frame, row', col'} and in_box_d1.
REQ-021 Stage 2 SHALL carry in_box_d2; rom_data is valid in this cycle.
REQ-022 Stage 3 SHALL register sprite_hit = in_box_d2 AND (rom_data != TRANSP_IDX), and sprite_index = rom_data when sprite_hit would be 1, else 0.
REQ-023 Total latency SHALL be 3 cycles from draw_x/draw_y to sprite_index/sprite_hit, at full throughput of one pixel per clock.
REQ-024 SHALL use a 4-state animation FSM: CLOSED(frame 0) -> HALF_OPEN(1) -> OPEN(2) -> HALF_CLOSE(1) -> CLOSED.
REQ-025 The anim_frame field SHALL be derived from the FSM state exactly as listed in REQ-024.
REQ-026 Divider counter, 4 bits:
- increments on frame_tick while pac_moving = 1;
- when it reaches ANIM_DIV-1 on a tick, it clears to 0 and the FSM advances one state.
REQ-027 With pac_moving = 0, the counter and FSM SHALL hold their current values.
REQ-028 A frame_tick while pac_moving = 1 SHALL update the shadow registers and the counter in the same cycle.
REQ-029 Out-of-box pixels SHALL still drive rom_addr, but sprite_hit SHALL be 0 and sprite_index SHALL be 0.

Reset
REQ-030 With reset_n = 0 at a clock edge, the following SHALL be 0: rom_addr, sprite_index, sprite_hit, all pipeline valid bits, the divider, and the shadow registers.
REQ-031 The FSM SHALL reset to CLOSED.
REQ-032 Reset SHALL take priority over frame_tick in the same cycle.
REQ-033 Reset mid-line SHALL flush the pipeline: no stale hit may appear for 3 cycles after release.

Configuration
REQ-034 Macro PACMAN_ANIM_EN defined: the animation FSM and divider are built as specified above.
REQ-035 Macro PACMAN_ANIM_EN undefined:
- the FSM and divider are omitted;
- anim_frame is constant 2'd0 (CLOSED);
- pac_moving is ignored.
All other behaviour is identical.

Verification
REQ-036 Reset: hold reset_n = 0 for 2 cycles, then release -> sprite_hit = 0, sprite_index = 0, FSM = CLOSED, rom_addr = 0.
REQ-037 Hit and latency:
- setup: pac = (100, 50), dir right, tick applied; ROM model returns 5'd13 everywhere;
- drive draw = (105, 53) at cycle T -> rom_addr = {00, 3, 5} at T+1; sprite_hit = 1 and sprite_index = 13 at T+3;
- drive draw = (116, 53) -> sprite_hit = 0.
REQ-038 Transparency: ROM model returns 5'd1 -> sprite_hit = 0 and sprite_index = 0 for all in-box pixels.
REQ-039 Direction:
- dir left, draw = (105, 53) -> rom_addr col = 10;
- dir down, same pixel -> rom_addr = {00, 10, 3}.
REQ-040 Animation:
- ANIM_DIV = 4, pac_moving = 1, 16 ticks -> frames step 0, 1, 2, 1, 0, changing every 4th tick;
- pac_moving = 0 for 8 ticks -> frame unchanged.
REQ-041 Edges and shadow timing:
- pac_x = 630: draw_x 639 gives a hit; draw_x 0 gives no hit;
- pac_x changed mid-frame with no tick -> the hit region stays at the old position until the next frame_tick.
